// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst codes and slave FSM state encoding.
// Shared by axi_sram_slave and axi_slv_arb.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_RD_REQ  = 5'b00010,
    ST_RD_RESP = 5'b00100,
    ST_WR_DATA = 5'b01000,
    ST_WR_RESP = 5'b10000
  } state_t;

  // INCR and WRAP both step one word; only FIXED holds.
  function automatic logic addr_step(input logic [1:0] burst);
    return (burst != BURST_FIXED);
  endfunction

endpackage

// File: rtl/axi_slv_arb.sv
// axi_slv_arb: 2-way round-robin grant between read and write requests.
// Ports: i_en gates grants, i_rd/wr_req requests, i_rd/wr_hs update, o_*_gnt.
module axi_slv_arb (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_rd_req,
  input  logic i_wr_req,
  input  logic i_rd_hs,
  input  logic i_wr_hs,
  output logic o_rd_gnt,
  output logic o_wr_gnt
);

  logic r_last_wr;
  logic w_rd_win;

  // Read wins when alone, or when both request and write went last.
  always_comb begin
    w_rd_win = i_rd_req & (~i_wr_req | r_last_wr);
    o_rd_gnt = i_en & w_rd_win;
    o_wr_gnt = i_en & i_wr_req & ~w_rd_win;
  end

  always_ff @(posedge clk) begin
    if (reset)        r_last_wr <= 1'b1;
    else if (i_rd_hs) r_last_wr <= 1'b0;
    else if (i_wr_hs) r_last_wr <= 1'b1;
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 32-bit slave onto a 1-cycle-latency single-port RAM.
// Ports: AR/R/AW/W/B channels, ram_* RAM side. Option: AXI_SLV_ADDR_CHECK_EN.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int RAM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_id;
  logic [RAM_AW-1:0] r_addr;
  logic [7:0]        r_len;
  logic [1:0]        r_burst;
  logic [7:0]        r_beat;
  logic              r_oor;
  logic              w_last;
  logic              w_adv;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_ar_oor;
  logic              w_aw_oor;
  logic              w_unused;

  assign w_unused = ^{arsize, arlock, arcache, arprot,
                      awsize, awlock, awcache, awprot,
                      wid, wlast, araddr, awaddr};

`ifdef AXI_SLV_ADDR_CHECK_EN
  assign w_ar_oor = |araddr[31:RAM_AW+2];
  assign w_aw_oor = |awaddr[31:RAM_AW+2];
`else
  assign w_ar_oor = 1'b0;
  assign w_aw_oor = 1'b0;
`endif

  axi_slv_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_en     ((r_state == ST_IDLE) & ~reset),
    .i_rd_req (arvalid),
    .i_wr_req (awvalid),
    .i_rd_hs  (w_ar_hs),
    .i_wr_hs  (w_aw_hs),
    .o_rd_gnt (arready),
    .o_wr_gnt (awready)
  );

  assign w_ar_hs = arvalid & arready;
  assign w_aw_hs = awvalid & awready;
  assign w_last  = (r_beat == r_len);

  assign rid       = r_id;
  assign bid       = r_id;
  assign rdata     = r_oor ? 32'd0 : ram_rdata;
  assign rlast     = (r_state == ST_RD_RESP) & w_last;
  assign rresp     = (rvalid & r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign bresp     = (bvalid & r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign ram_addr  = r_addr;
  assign ram_wdata = wdata;

  always_comb begin
    w_state_nxt = r_state;
    rvalid      = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 4'd0;
    w_adv       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ar_hs)      w_state_nxt = ST_RD_REQ;
        else if (w_aw_hs) w_state_nxt = ST_WR_DATA;
      end
      ST_RD_REQ: begin
        ram_en      = ~r_oor;
        w_state_nxt = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          w_adv       = ~w_last;
          w_state_nxt = w_last ? ST_IDLE : ST_RD_REQ;
        end
      end
      ST_WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en = ~r_oor;
          ram_we = r_oor ? 4'd0 : wstrb;
          w_adv  = ~w_last;
          if (w_last) w_state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= 4'd0;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_burst <= BURST_INCR;
      r_beat  <= 8'd0;
      r_oor   <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= arid;
      r_addr  <= araddr[RAM_AW+1:2];
      r_len   <= arlen;
      r_burst <= arburst;
      r_beat  <= 8'd0;
      r_oor   <= w_ar_oor;
    end else if (w_aw_hs) begin
      r_id    <= awid;
      r_addr  <= awaddr[RAM_AW+1:2];
      r_len   <= awlen;
      r_burst <= awburst;
      r_beat  <= 8'd0;
      r_oor   <= w_aw_oor;
    end else if (w_adv) begin
      r_beat <= r_beat + 8'd1;
      if (addr_step(r_burst)) r_addr <= r_addr + 1'b1;
    end
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style 32-bit slave (responder) terminating the AR/R/AW/W/B channels driven by the CPU-side AXI master bridge.
- Maps AXI transactions onto a single-port synchronous RAM with a 1-cycle read latency.
- Serves as a memory model for system simulation and as on-chip RAM behind the interconnect.
- Processes one transaction at a time. Reads and writes share the RAM through round-robin arbitration.

Parameters:
- RAM_AW, 16, word-address width; RAM holds 2^RAM_AW 32-bit words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel
- arlock/arcache/arprot  in  2/4/3  accepted, ignored
- arvalid  in  1;  arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1;  rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address channel
- awlock/awcache/awprot  in  2/4/3  ignored
- awvalid  in  1;  awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1 (wid, wlast ignored);  wready  out  1
- bid/bresp/bvalid  out  4/2/1;  bready  in  1
- ram_en  out  1  RAM access enable
- ram_we  out  4  byte write enables
- ram_addr  out  RAM_AW  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data; valid the cycle after ram_en with ram_we=0; held until the next ram_en

Behaviour:
- Clock/reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: state IDLE, all valid/ready outputs 0, ram_en 0, ram_we 0, rid/bid/rresp/bresp 0, last_grant = write, so the read side wins first.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - Grant: read if only arvalid; write if only awvalid; if both, the side opposite last_grant.
  - arready/awready are combinational: asserted only in IDLE, only to the granted side, and only while reset is low.
  - On a handshake, latch id, word address (addr[RAM_AW+1:2]), len and burst. Clear beat count. Go to RD_REQ or WR_DATA and update last_grant.
- RD_REQ: ram_en=1, ram_we=0, ram_addr=current address → RD_RESP.
- RD_RESP:
  - rvalid=1, rdata=ram_rdata, rid=latched id, rresp=OKAY, rlast=(beat==len).
  - All R outputs stay stable until rready.
  - On handshake: if rlast → IDLE; else beat+1, advance address, → RD_REQ.
- Read latency: AR handshake at edge T → ram_en in cycle T+1 → rvalid in cycle T+2. Sustained burst rate is 1 beat per 2 cycles.
- WR_DATA:
  - wready=1.
  - On wvalid: in the same cycle ram_en=1, ram_we=wstrb, ram_addr=current address, ram_wdata=wdata.
  - If beat==len → WR_RESP; else beat+1 and advance address.
  - Burst end is set by the internal count; wlast is not checked.
- WR_RESP: bvalid=1, bid=latched awid, bresp=OKAY; on bready → IDLE.
- Address advance: INCR (01) and WRAP (10) → word address +1, wrapping modulo 2^RAM_AW. FIXED (00) → unchanged.
- Width rules:
  - Size is ignored; every beat is a full 32-bit word. Narrow writes rely on wstrb. Narrow reads return the whole word.
  - addr[1:0] ignored.
  - len is 8-bit, so bursts are up to 256 beats.
- Reset mid-transaction: abandons the burst. Next cycle is IDLE with all valids 0; no B/R response is issued for the aborted burst.
- A new AR or AW is never accepted outside IDLE, so no outstanding transactions exist.

Optional Feature:
- Macro: AXI_SLV_ADDR_CHECK_EN.
- Defined:
  - A transaction whose start address has nonzero bits in [31:RAM_AW+2] is flagged out-of-range for the whole burst.
  - Reads still sequence normally but return rdata=0 and rresp=SLVERR (2'b10), with ram_en held at 0.
  - Writes accept every W beat with ram_en=0 and ram_we=0, then return bresp=SLVERR.
- Undefined: upper address bits are ignored (aliasing) and responses are always OKAY.

Decomposition:
- Package axi_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; BURST_FIXED/INCR/WRAP codes; FSM state encoding (one-hot, 5 bits).
- Sub-module axi_slv_arb: 2-way round-robin grant with last_grant register and update-on-handshake input.

Test Plan:
- Single read: mem[0x10]=0xDEADBEEF; araddr=0x40, arid=1, arlen=0 → arready same cycle, rvalid 2 cycles later, rdata=0xDEADBEEF, rid=1, rlast=1, rresp=00.
- Strobed write: mem[0x3]=0x11223344; awaddr=0xC, awid=1, wdata=0xAABBCCDD, wstrb=4'b0101 → mem[0x3]=0x11BB33DD, bvalid with bid=1, bresp=00.
- INCR read burst: araddr=0x100, arlen=3, rready toggling 1/0 → 4 beats from words 0x40..0x43, rlast on beat 4 only, rdata stable while rready=0.
- Arbitration: arvalid and awvalid both high after reset → read granted first; issue both again → write granted first.
- Reset mid-burst: reset asserted during beat 2 of an arlen=7 read → next cycle rvalid=0; a new AR is accepted immediately after reset deasserts.
- With AXI_SLV_ADDR_CHECK_EN (RAM_AW=16): araddr=0x0004_0000 → rdata=0, rresp=10. Write to the same address → ram_we stays 0, bresp=10, memory unchanged.
